spi_duty_rx: RTL and testbench



---
 rtl/spi_duty_rx_if.sv | 26 ++
 rtl/spi_duty_rx.sv | 185 ++++++++++++++++++
 tb/tb_spi_duty_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_duty_rx_if.sv
// spi_duty_rx_if: SPI pins plus the duty/strobe outputs that feed the PWM generator.
// Latency: none; this is only a bundle of wires.
// Backpressure: none; the SPI master paces all traffic and the PWM side always accepts.
interface spi_duty_rx_if #(
   parameter int NUM_CH = 3
);
   logic                sclk;
   logic                ss_n;
   logic                mosi;
   logic                miso;
   logic [NUM_CH*8-1:0] duty;
   logic                duty_update;
   logic [2:0]          update_ch;
   logic                frame_err;
   logic                busy;

   modport slave (
      input  sclk, ss_n, mosi,
      output miso, duty, duty_update, update_ch, frame_err, busy
   );

   modport master (
      output sclk, ss_n, mosi,
      input  miso, duty, duty_update, update_ch, frame_err, busy
   );
endinterface

// File: rtl/spi_duty_rx.sv
// spi_duty_rx: oversampled SPI mode-0 slave decoding 16-bit frames into NUM_CH duty registers.
// Latency: duty/duty_update/frame_err change SYNC_STAGES+2 clk cycles after ss_n rises at the pin.
// Backpressure: none; clk must be >= 8x sclk. FRAME_PARITY_EN makes bit 11 an odd-parity bit.
module spi_duty_rx #(
   parameter int NUM_CH      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   spi_duty_rx_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic                   ss_dly_q, ss_dly_d;
   logic                   armed_q, armed_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [15:0]            rx_shift_q, rx_shift_d;
   logic [15:0]            tx_shift_q, tx_shift_d;
   logic                   miso_q, miso_d;
   logic [NUM_CH*8-1:0]    duty_q, duty_d;
   logic                   duty_update_q, duty_update_d;
   logic [2:0]             update_ch_q, update_ch_d;
   logic                   frame_err_q, frame_err_d;
   logic [2:0]             rd_ch_q, rd_ch_d;
   logic [7:0]             frame_cnt_q, frame_cnt_d;

   logic       sclk_s, ss_s, mosi_s;
   logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [2:0] rx_ch;
   logic       ch_ok, par_ok, frame_ok;
   logic [7:0] rd_duty;
   logic       unused_bits;

   // Synchroniser chains, edge-detect delay copies and the post-reset priming tracker.
   // A falling ss_n only counts once ss_n has been seen high on real pin samples, so a
   // frame interrupted by reset is ignored until ss_n is released and asserted again.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_d  = sclk_s;
      ss_dly_d    = ss_s;
      armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign ss_rise   = ss_s & ~ss_dly_q;
   assign ss_fall   = armed_q & ~ss_s & ss_dly_q;

   assign rx_ch    = rx_shift_q[14:12];
   assign ch_ok    = ({29'd0, rx_ch} < 32'(NUM_CH));
   assign frame_ok = (bit_cnt_q == 5'd16) && ch_ok && par_ok;

`ifdef FRAME_PARITY_EN
   assign par_ok      = ^{rx_shift_q[15:12], rx_shift_q[7:0], rx_shift_q[11]};
   assign unused_bits = ^{tx_shift_q[15], rx_shift_q[10:8]};
`else
   assign par_ok      = 1'b1;
   assign unused_bits = ^{tx_shift_q[15], rx_shift_q[11:8]};
`endif

   // Readback mux: duty value of the channel selected by the last good read frame.
   always_comb begin
      rd_duty = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_ch_q == 3'(k)) rd_duty = duty_q[8*k +: 8];
      end
   end

   // Frame FSM: shift in/out while ACTIVE, decode and commit in the single DONE cycle.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      miso_d        = miso_q;
      duty_d        = duty_q;
      duty_update_d = 1'b0;
      update_ch_d   = 3'd0;
      frame_err_d   = 1'b0;
      rd_ch_d       = rd_ch_q;
      frame_cnt_d   = frame_cnt_q;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d    = ACTIVE;
               bit_cnt_d  = 5'd0;
               tx_shift_d = {frame_cnt_q, rd_duty};
               miso_d     = frame_cnt_q[7];
            end
         end
         ACTIVE: begin
            // ss_n release has priority over any sclk edge seen in the same cycle.
            if (ss_rise) begin
               state_d = DONE;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[14:0], mosi_s};
               if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
            end else if (sclk_fall) begin
               tx_shift_d = {tx_shift_q[14:0], 1'b0};
               miso_d     = tx_shift_q[14];
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!frame_ok) begin
               frame_err_d = 1'b1;
            end else begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               if (rx_shift_q[15]) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (rx_ch == 3'(k)) duty_d[8*k +: 8] = rx_shift_q[7:0];
                  end
                  duty_update_d = 1'b1;
                  update_ch_d   = rx_ch;
               end else begin
                  rd_ch_d = rx_ch;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sclk_sync_q   <= '0;
         ss_sync_q     <= '1;
         mosi_sync_q   <= '0;
         fill_q        <= '0;
         sclk_dly_q    <= 1'b0;
         ss_dly_q      <= 1'b1;
         armed_q       <= 1'b0;
         bit_cnt_q     <= 5'd0;
         rx_shift_q    <= 16'd0;
         tx_shift_q    <= 16'd0;
         miso_q        <= 1'b0;
         duty_q        <= '0;
         duty_update_q <= 1'b0;
         update_ch_q   <= 3'd0;
         frame_err_q   <= 1'b0;
         rd_ch_q       <= 3'd0;
         frame_cnt_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= sclk_sync_d;
         ss_sync_q     <= ss_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         fill_q        <= fill_d;
         sclk_dly_q    <= sclk_dly_d;
         ss_dly_q      <= ss_dly_d;
         armed_q       <= armed_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         miso_q        <= miso_d;
         duty_q        <= duty_d;
         duty_update_q <= duty_update_d;
         update_ch_q   <= update_ch_d;
         frame_err_q   <= frame_err_d;
         rd_ch_q       <= rd_ch_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign bus.miso        = miso_q;
   assign bus.duty        = duty_q;
   assign bus.duty_update = duty_update_q;
   assign bus.update_ch   = update_ch_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_duty_rx.sv
// tb_spi_duty_rx: drives SPI frames, predicts decode results and checks them on a scoreboard.
// Latency: checks strobes arrive SYNC_STAGES+2 cycles after ss_n release.
// Backpressure: none; sclk runs at 1/16 of clk.
module tb_spi_duty_rx;
   localparam int NUM_CH = 3;
   localparam int SYNC   = 2;
   localparam int HALF   = 8;

   typedef struct {
      logic        err;
      logic [2:0]  ch;
      logic [31:0] duty_vec;
   } sb_ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   spi_duty_rx_if #(.NUM_CH(NUM_CH)) bus ();

   spi_duty_rx #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int      n_chk = 0;
   int      n_bad = 0;
   int      cyc = 0;
   int      raise_cyc = 0;
   int      evt_cnt = 0;
   sb_ent_t sb[$];
   sb_ent_t mon_e;

   logic [7:0] m_duty [NUM_CH];
   logic [7:0] m_fcnt;
   logic [2:0] m_rdch;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_vec();
      logic [31:0] v = '0;
      for (int k = 0; k < NUM_CH; k++) v[8*k +: 8] = m_duty[k];
      return v;
   endfunction

   function automatic logic par_ok(input logic [15:0] w);
`ifdef FRAME_PARITY_EN
      return ^{w[15:12], w[7:0], w[11]};
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) m_duty[k] = 8'd0;
      m_fcnt = 8'd0;
      m_rdch = 3'd0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer: every strobe must match the oldest predicted event.
   always @(negedge clk) begin
      if (bus.duty_update || bus.frame_err) begin
         evt_cnt++;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("evt_err", 32'(bus.frame_err), 32'(mon_e.err));
            chk("evt_upd", 32'(bus.duty_update), 32'(!mon_e.err));
            if (!mon_e.err) chk("upd_ch", 32'(bus.update_ch), 32'(mon_e.ch));
            chk("duty_vec", 32'(bus.duty), mon_e.duty_vec);
            chk("latency", 32'(cyc - raise_cyc), 32'(SYNC + 2));
         end
      end
   end

   task automatic ss_low();
      @(negedge clk);
      bus.ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic ss_high();
      repeat (HALF) @(negedge clk);
      bus.ss_n  = 1'b1;
      raise_cyc = cyc;
      repeat (2*HALF) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [31:0] word, input int nbits, output logic [31:0] cap);
      cap = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.mosi = word[i];
         repeat (HALF) @(negedge clk);
         cap = {cap[30:0], bus.miso};
         bus.sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] word, input int nbits);
      logic [15:0] exp_miso;
      logic [31:0] cap;
      logic [2:0]  ch;
      logic        ok;
      sb_ent_t     e;
      exp_miso = {m_fcnt, m_duty[m_rdch]};
      ss_low();
      shift_bits(word, nbits, cap);
      ch = word[14:12];
      ok = (nbits == 16) && (int'(ch) < NUM_CH) && par_ok(word[15:0]);
      e.ch = ch;
      if (!ok) begin
         e.err = 1'b1;
      end else begin
         e.err  = 1'b0;
         m_fcnt = m_fcnt + 8'd1;
         if (word[15]) m_duty[ch] = word[7:0];
         else          m_rdch = ch;
      end
      e.duty_vec = m_vec();
      if (e.err || word[15]) sb.push_back(e);
      if (nbits == 16) chk("miso_word", {16'd0, cap[15:0]}, {16'd0, exp_miso});
      ss_high();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_duty"}, 32'(bus.duty), 32'd0);
      chk({tag, "_miso"}, 32'(bus.miso), 32'd0);
      chk({tag, "_upd"},  32'(bus.duty_update), 32'd0);
      chk({tag, "_uch"},  32'(bus.update_ch), 32'd0);
      chk({tag, "_err"},  32'(bus.frame_err), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cap;
      int          evt_before;
      bus.sclk = 1'b0;
      bus.ss_n = 1'b1;
      bus.mosi = 1'b0;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      send_frame(32'h90C8, 16);
      send_frame(32'h1000, 16);
      send_frame(32'h0000, 16);
      send_frame(32'h1234, 15);
      send_frame(32'h1234, 17);
      send_frame(32'hD055, 16);
      send_frame(32'h5000, 16);
      send_frame(32'hA037, 16);
      send_frame(32'h98C8, 16);
      send_frame(32'h8801, 16);

      // Reset in the middle of a write frame, ss_n kept low across reset.
      ss_low();
      shift_bits(32'h90, 8, cap);
      chk("busy_mid", 32'(bus.busy), 32'd1);
      #3 rst_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("busy_after_rst", 32'(bus.busy), 32'd0);
      evt_before = evt_cnt;
      ss_high();
      repeat (20) @(negedge clk);
      chk("no_evt_after_rst", 32'(evt_cnt - evt_before), 32'd0);

      send_frame(32'hA037, 16);
      send_frame(32'h2000, 16);
      send_frame(32'h0000, 16);

      repeat (20) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
